execute_unit: RTL and testbench
===============================

EXECUTE_UNIT -- requirements
Module: execute_unit

Interface
REQ-001 The block SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 The block SHALL have ports in_valid, stall and bubble, each input, 1: stage input valid, hold output register, and insert bubble.
REQ-004 The block SHALL have ports icode and ifun, input, 4 each: decoded Y-86 instruction code and function.
REQ-005 The block SHALL have ports valA, valB and valC, input, 64 each: register operands and immediate/displacement.
REQ-006 The block SHALL have port dstE, input, 4: destination register for valE (0xF = none).
REQ-007 The block SHALL have port cc_inhibit, input, 1: suppresses the CC update (downstream exception).
REQ-008 The block SHALL have ports alu_a and alu_b, output, 64 each, combinational operands to the external ALU.
REQ-009 The block SHALL have port alu_s, output, 2, combinational ALU select (00 add, 01 sub = alu_a-alu_b, 10 and, 11 xor).
REQ-010 The block SHALL have port alu_result, input, 64, combinational ALU result in the same cycle.
REQ-011 The block SHALL have ports ovf_add and ovf_sub, input, 1 each, ALU signed-overflow flags.
REQ-012 The block SHALL have ports out_valid, out_icode, out_valE, out_valA, out_dstE, out_cnd and out_err, registered outputs of widths 1/4/64/64/4/1/1.
REQ-013 The block SHALL have port cc, output, 3, current {ZF,SF,OF}.

Function
REQ-014 alu_a SHALL be valB for icodes 4,5,6,8,9,A,B and 0 for icodes 2,3 and all others.
REQ-015 alu_b SHALL be valA for icodes 2,6; valC for 3,4,5; 64'hFFFF_FFFF_FFFF_FFF8 (-8) for 8,A; 64'd8 for 9,B; 0 otherwise.
REQ-016 alu_s SHALL be ifun[1:0] when icode==6 and ifun<=3, else 00.
REQ-017 Condition Cnd SHALL be evaluated from current cc for icode 2 or 7: ifun 0 ->1; 1 ->(SF^OF)|ZF; 2 ->SF^OF; 3 ->ZF; 4 ->~ZF; 5 ->~(SF^OF); 6 ->~(SF^OF)&~ZF; ifun>6 ->0.
REQ-018 For any other icode, Cnd SHALL be 0.
REQ-019 The CC update enable SHALL be in_valid & icode==6 & ~stall & ~bubble & ~cc_inhibit & ~rst.
REQ-020 On the CC update, ZF SHALL load (alu_result==0) and SF SHALL load alu_result[63].
REQ-021 On the CC update, OF SHALL load ovf_add for ifun 0, ovf_sub for ifun 1, and 0 for ifun 2,3.
REQ-022 Cnd SHALL use cc before the current instruction's update, so an OPq followed by a jXX sees the new flags one cycle later.
REQ-023 The output register SHALL have 1-cycle latency: on an edge with ~stall & ~bubble it loads out_valid=in_valid, out_icode=icode, out_valE=alu_result, out_valA=valA, out_cnd=Cnd.
REQ-024 out_dstE SHALL load 0xF when icode==2 and Cnd==0, else dstE.
REQ-025 out_err SHALL load 1 when in_valid and (icode>0xB, or icode==6 with ifun>3, or icode in {2,7} with ifun>6).
REQ-026 When out_err loads 1, the CC SHALL NOT update and out_dstE SHALL load 0xF.
REQ-027 On stall=1, every output register and the CC SHALL hold.
REQ-028 stall SHALL take priority over bubble when both are asserted.
REQ-029 On bubble=1 and stall=0, the output register SHALL load out_valid=0, out_icode=1 (nop), out_dstE=0xF, out_cnd=0, out_err=0, out_valE=0 and out_valA=0; CC SHALL hold.
REQ-030 in_valid=0 without bubble SHALL load the output register as a bubble and SHALL NOT update CC.
REQ-031 The ALU operand, select and Cnd logic SHALL be purely combinational; the CC and output registers are the only state.

Reset
REQ-032 On rst=1 at an edge, cc SHALL become {ZF=1,SF=0,OF=0}.
REQ-033 On rst=1 at an edge, the output register SHALL take bubble values (REQ-029), overriding stall and bubble.
REQ-034 A reset in the middle of a stream SHALL discard the in-flight instruction with no CC update.

Verification
REQ-035 The bench SHALL drive OPq subq (icode 6, ifun 1) valA=5, valB=5 -> alu_s=01, alu_a=5, alu_b=5; next edge cc={1,0,0}, out_valE=0.
REQ-036 The bench SHALL drive addq valA=1, valB=64'h7FFF_FFFF_FFFF_FFFF -> cc={0,1,1}, then jXX ifun 2 (jl) -> out_cnd=0; ifun 1 (jle) -> out_cnd=0.
REQ-037 The bench SHALL drive cmovne (icode 2, ifun 4) with ZF=1 and dstE=3 -> out_dstE=0xF, out_valE=valA.
REQ-038 The bench SHALL drive pushq valB=0x100 -> alu_b=-8, out_valE=0xF8; popq valB=0x100 -> out_valE=0x108; cc unchanged in both cases.
REQ-039 The bench SHALL drive stall=1 and bubble=1 together with a valid addq -> outputs and cc hold; then bubble alone -> out_valid=0, out_icode=1.
REQ-040 The bench SHALL drive icode=0xC, and separately OPq with ifun=5 -> out_err=1, cc unchanged; then rst=1 -> cc={1,0,0}, out_valid=0.

Source files
------------

// File: rtl/execute_unit.sv
// Y-86 execute stage: drives operands/select to an external ALU, evaluates the
// branch/cmov condition from the current flags, and registers results for memory.
module execute_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        stall,
    input  logic        bubble,
    input  logic [3:0]  icode,
    input  logic [3:0]  ifun,
    input  logic [63:0] valA,
    input  logic [63:0] valB,
    input  logic [63:0] valC,
    input  logic [3:0]  dstE,
    input  logic        cc_inhibit,
    output logic [63:0] alu_a,
    output logic [63:0] alu_b,
    output logic [1:0]  alu_s,
    input  logic [63:0] alu_result,
    input  logic        ovf_add,
    input  logic        ovf_sub,
    output logic        out_valid,
    output logic [3:0]  out_icode,
    output logic [63:0] out_valE,
    output logic [63:0] out_valA,
    output logic [3:0]  out_dstE,
    output logic        out_cnd,
    output logic        out_err,
    output logic [2:0]  cc
);

    localparam logic [3:0] I_CMOV = 4'h2;
    localparam logic [3:0] I_OPQ  = 4'h6;
    localparam logic [3:0] I_JXX  = 4'h7;
    localparam logic [3:0] I_NOP  = 4'h1;
    localparam logic [3:0] R_NONE = 4'hF;

    logic zf, sf, of_flag;
    logic cond_true;
    logic cnd;
    logic err;
    logic cc_en;
    logic of_next;

    assign zf      = cc[2];
    assign sf      = cc[1];
    assign of_flag = cc[0];

    always_comb begin
        alu_a = '0;
        alu_b = '0;
        case (icode)
            4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB: alu_a = valB;
            default: alu_a = '0;
        endcase
        case (icode)
            4'h2, 4'h6:       alu_b = valA;
            4'h3, 4'h4, 4'h5: alu_b = valC;
            4'h8, 4'hA:       alu_b = 64'hFFFF_FFFF_FFFF_FFF8;
            4'h9, 4'hB:       alu_b = 64'd8;
            default:          alu_b = '0;
        endcase
        alu_s = (icode == I_OPQ && ifun <= 4'd3) ? ifun[1:0] : 2'b00;
    end

    // Condition uses the flags as they stand before this instruction's update.
    always_comb begin
        cond_true = 1'b0;
        case (ifun)
            4'd0:    cond_true = 1'b1;
            4'd1:    cond_true = (sf ^ of_flag) | zf;
            4'd2:    cond_true = sf ^ of_flag;
            4'd3:    cond_true = zf;
            4'd4:    cond_true = ~zf;
            4'd5:    cond_true = ~(sf ^ of_flag);
            4'd6:    cond_true = ~(sf ^ of_flag) & ~zf;
            default: cond_true = 1'b0;
        endcase
        cnd = (icode == I_CMOV || icode == I_JXX) ? cond_true : 1'b0;
    end

    always_comb begin
        err = in_valid & ((icode > 4'hB)
                        | (icode == I_OPQ && ifun > 4'd3)
                        | ((icode == I_CMOV || icode == I_JXX) && ifun > 4'd6));
        cc_en = in_valid & (icode == I_OPQ) & ~stall & ~bubble & ~cc_inhibit & ~err;
        case (ifun)
            4'd0:    of_next = ovf_add;
            4'd1:    of_next = ovf_sub;
            default: of_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cc <= 3'b100;
        end else if (cc_en) begin
            cc <= {(alu_result == 64'd0), alu_result[63], of_next};
        end
    end

    // Reset and bubbles both leave a nop in the output register; stall holds it.
    always_ff @(posedge clk) begin
        if (rst || (!stall && (bubble || !in_valid))) begin
            out_valid <= 1'b0;
            out_icode <= I_NOP;
            out_valE  <= '0;
            out_valA  <= '0;
            out_dstE  <= R_NONE;
            out_cnd   <= 1'b0;
            out_err   <= 1'b0;
        end else if (!stall) begin
            out_valid <= 1'b1;
            out_icode <= icode;
            out_valE  <= alu_result;
            out_valA  <= valA;
            out_dstE  <= (err || (icode == I_CMOV && !cnd)) ? R_NONE : dstE;
            out_cnd   <= cnd;
            out_err   <= err;
        end
    end

endmodule

// File: tb/tb_execute_unit.sv
// Randomized + directed bench for execute_unit with an external ALU model and
// a scoreboard fed by a spec-level reference model.
module tb_execute_unit;

    localparam int W = 142;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        stall;
    logic        bubble;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [63:0] valC;
    logic [3:0]  dstE;
    logic        cc_inhibit;
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [1:0]  alu_s;
    logic [63:0] alu_result;
    logic        ovf_add;
    logic        ovf_sub;
    logic        out_valid;
    logic [3:0]  out_icode;
    logic [63:0] out_valE;
    logic [63:0] out_valA;
    logic [3:0]  out_dstE;
    logic        out_cnd;
    logic        out_err;
    logic [2:0]  cc;

    execute_unit dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .bubble(bubble),
        .icode(icode), .ifun(ifun), .valA(valA), .valB(valB), .valC(valC),
        .dstE(dstE), .cc_inhibit(cc_inhibit), .alu_a(alu_a), .alu_b(alu_b),
        .alu_s(alu_s), .alu_result(alu_result), .ovf_add(ovf_add), .ovf_sub(ovf_sub),
        .out_valid(out_valid), .out_icode(out_icode), .out_valE(out_valE),
        .out_valA(out_valA), .out_dstE(out_dstE), .out_cnd(out_cnd),
        .out_err(out_err), .cc(cc)
    );

    // Clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // External ALU
    always_comb begin
        case (alu_s)
            2'b00:   alu_result = alu_a + alu_b;
            2'b01:   alu_result = alu_a - alu_b;
            2'b10:   alu_result = alu_a & alu_b;
            default: alu_result = alu_a ^ alu_b;
        endcase
        ovf_add = (alu_a[63] == alu_b[63]) && ((alu_a + alu_b) >> 63 != {63'd0, alu_a[63]});
        ovf_sub = (alu_a[63] != alu_b[63]) && ((alu_a - alu_b) >> 63 != {63'd0, alu_a[63]});
    end

    // Scoreboard
    logic [W-1:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;
    logic [W-1:0] mon_exp;
    logic [W-1:0] mon_act;

    // Reference model state
    logic [2:0]  m_cc;
    logic        m_valid;
    logic [3:0]  m_icode;
    logic [63:0] m_valE;
    logic [63:0] m_valA;
    logic [3:0]  m_dstE;
    logic        m_cnd;
    logic        m_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_act = {out_valid, out_icode, out_valE, out_valA, out_dstE, out_cnd, out_err, cc};
            n_cmp++;
            if (mon_act !== mon_exp) begin
                n_fail++;
                $display("FAIL scoreboard @%0t: got %h expected %h", $time, mon_act, mon_exp);
            end
        end
    end

    function automatic logic cond(input logic [2:0] c, input logic [3:0] fn);
        logic z, s, o;
        z = c[2];
        s = c[1];
        o = c[0];
        case (fn)
            4'd0: return 1'b1;
            4'd1: return (s != o) || z;
            4'd2: return s != o;
            4'd3: return z;
            4'd4: return !z;
            4'd5: return s == o;
            4'd6: return (s == o) && !z;
            default: return 1'b0;
        endcase
    endfunction

    // Signed overflow via 65-bit arithmetic: the result leaves the 64-bit range.
    function automatic logic sovf(input logic [63:0] x, input logic [63:0] y, input logic is_sub);
        logic [64:0] r;
        r = is_sub ? ({x[63], x} - {y[63], y}) : ({x[63], x} + {y[63], y});
        return r[64] != r[63];
    endfunction

    function automatic logic [63:0] ref_val(input logic [3:0] ic, input logic [3:0] fn,
                                            input logic [63:0] a, input logic [63:0] b,
                                            input logic [63:0] c);
        case (ic)
            4'h2: return a;
            4'h3: return c;
            4'h4, 4'h5: return b + c;
            4'h6: begin
                case (fn)
                    4'd1: return b - a;
                    4'd2: return b & a;
                    4'd3: return b ^ a;
                    default: return b + a;
                endcase
            end
            4'h8, 4'hA: return b - 64'd8;
            4'h9, 4'hB: return b + 64'd8;
            default: return 64'd0;
        endcase
    endfunction

    task automatic set_bubble();
        m_valid = 1'b0;
        m_icode = 4'h1;
        m_valE  = '0;
        m_valA  = '0;
        m_dstE  = 4'hF;
        m_cnd   = 1'b0;
        m_err   = 1'b0;
    endtask

    // Driver: present one cycle of stimulus and push the expected post-edge state.
    task automatic apply(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                         input logic [3:0] d, input logic st, input logic bu,
                         input logic inh, input logic r);
        logic e, cn, of_n;
        logic [63:0] res;
        rst = r; in_valid = v; icode = ic; ifun = fn; valA = a; valB = b; valC = c;
        dstE = d; stall = st; bubble = bu; cc_inhibit = inh;
        cn  = (ic == 4'h2 || ic == 4'h7) ? cond(m_cc, fn) : 1'b0;
        e   = v && (ic > 4'hB || (ic == 4'h6 && fn > 4'd3) || ((ic == 4'h2 || ic == 4'h7) && fn > 4'd6));
        res = ref_val(ic, fn, a, b, c);
        if (r) begin
            m_cc = 3'b100;
            set_bubble();
        end else if (!st) begin
            if (bu || !v) begin
                set_bubble();
            end else begin
                if (ic == 4'h6 && !e && !inh) begin
                    of_n = (fn == 4'd0) ? sovf(b, a, 1'b0) : (fn == 4'd1) ? sovf(b, a, 1'b1) : 1'b0;
                    m_cc = {res == 64'd0, res[63], of_n};
                end
                m_valid = 1'b1;
                m_icode = ic;
                m_valE  = res;
                m_valA  = a;
                m_dstE  = (e || (ic == 4'h2 && !cn)) ? 4'hF : d;
                m_cnd   = cn;
                m_err   = e;
            end
        end
        exp_q.push_back({m_valid, m_icode, m_valE, m_valA, m_dstE, m_cnd, m_err, m_cc});
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 3))
            0: return 64'($urandom_range(0, 15));
            1: return ($urandom_range(0, 1) == 0) ? 64'h7FFF_FFFF_FFFF_FFFF : 64'h8000_0000_0000_0000;
            2: return 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 3));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        logic [31:0] r32;
        logic [3:0]  ric, rfn;
        logic [63:0] ra, rb;
        m_cc = 3'b100;
        set_bubble();

        // Reset
        apply(1'b0, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        apply(1'b0, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        chk("reset_cc", 64'(cc), 64'h4);
        chk("reset_out_valid", 64'(out_valid), 64'd0);

        // subq 5,5
        apply(1'b1, 4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("subq_alu_s", 64'(alu_s), 64'd1);
        chk("subq_alu_a", alu_a, 64'd5);
        chk("subq_alu_b", alu_b, 64'd5);
        tick();
        chk("subq_cc", 64'(cc), 64'h4);
        chk("subq_valE", out_valE, 64'd0);

        // addq overflow, then jl / jle
        apply(1'b1, 4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("addq_cc", 64'(cc), 64'h3);
        apply(1'b1, 4'h7, 4'h2, 64'd0, 64'd0, 64'h40, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("jl_cnd", 64'(out_cnd), 64'd0);
        apply(1'b1, 4'h7, 4'h1, 64'd0, 64'd0, 64'h40, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("jle_cnd", 64'(out_cnd), 64'd0);

        // Set ZF, then cmovne must not write
        apply(1'b1, 4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        apply(1'b1, 4'h2, 4'h4, 64'h1234, 64'd0, 64'd0, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("cmovne_dstE", 64'(out_dstE), 64'hF);
        chk("cmovne_valE", out_valE, 64'h1234);

        // pushq / popq
        apply(1'b1, 4'hA, 4'h0, 64'd0, 64'h100, 64'd0, 4'h4, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pushq_alu_b", alu_b, 64'hFFFF_FFFF_FFFF_FFF8);
        tick();
        chk("pushq_valE", out_valE, 64'hF8);
        chk("pushq_cc", 64'(cc), 64'h4);
        apply(1'b1, 4'hB, 4'h0, 64'd0, 64'h100, 64'd0, 4'h4, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("popq_valE", out_valE, 64'h108);
        chk("popq_cc", 64'(cc), 64'h4);

        // stall + bubble holds; bubble alone inserts nop
        apply(1'b1, 4'h6, 4'h0, 64'd1, 64'd2, 64'd0, 4'h5, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk("stall_valE", out_valE, 64'h108);
        chk("stall_icode", 64'(out_icode), 64'hB);
        chk("stall_cc", 64'(cc), 64'h4);
        apply(1'b1, 4'h6, 4'h0, 64'd1, 64'd2, 64'd0, 4'h5, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("bubble_valid", 64'(out_valid), 64'd0);
        chk("bubble_icode", 64'(out_icode), 64'd1);

        // Illegal instructions, then reset mid-stream
        apply(1'b1, 4'hC, 4'h0, 64'd3, 64'd3, 64'd0, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("badicode_err", 64'(out_err), 64'd1);
        chk("badicode_cc", 64'(cc), 64'h4);
        apply(1'b1, 4'h6, 4'h5, 64'd3, 64'd4, 64'd0, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("badfun_err", 64'(out_err), 64'd1);
        chk("badfun_dstE", 64'(out_dstE), 64'hF);
        chk("badfun_cc", 64'(cc), 64'h4);
        apply(1'b1, 4'h6, 4'h0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, 4'h1,
              1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        chk("rst_cc", 64'(cc), 64'h4);
        chk("rst_valid", 64'(out_valid), 64'd0);

        // Randomized stream
        for (int i = 0; i < 500; i++) begin
            r32 = $urandom;
            ric = ($urandom_range(0, 2) == 0) ? 4'h6 : r32[3:0];
            rfn = {r32[8] & r32[9], r32[7:5]};
            ra  = rnd64();
            rb  = ($urandom_range(0, 3) == 0) ? ra : rnd64();
            apply(r32[15:12] != 4'd0, ric, rfn, ra, rb, rnd64(), r32[19:16],
                  $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
            chk("rand_alu_s", 64'(alu_s),
                (ric == 4'h6 && rfn <= 4'd3) ? 64'(rfn[1:0]) : 64'd0);
            tick();
        end

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) tick();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
